// File: rtl/datapath_pkg.sv
// Shared datapath types for the functional-unit status table.
// Field widths here bound the OP_W/REG_W/FU_W parameters of the table.
package datapath_pkg;

  localparam int DP_OP_W  = 4;
  localparam int DP_REG_W = 5;
  localparam int DP_TAG_W = 4;

  typedef struct packed {
    logic                busy;
    logic [DP_OP_W-1:0]  op;
    logic [DP_REG_W-1:0] rd;
    logic [DP_REG_W-1:0] rs1;
    logic [DP_REG_W-1:0] rs2;
    logic [DP_TAG_W-1:0] t1;
    logic [DP_TAG_W-1:0] t2;
    logic                r1;
    logic                r2;
    logic                disp;
  } fust_row_t;

  function automatic logic row_ready(input fust_row_t r);
    return r.busy & r.r1 & r.r2 & ~r.disp;
  endfunction

endpackage

// File: rtl/fust_table_if.sv
// Issue / dispatch / writeback bus of the FU status table.
interface fust_table_if #(
  parameter int NUM_FU = 4,
  parameter int REG_W  = 5,
  parameter int OP_W   = 4
);
  localparam int FU_W = $clog2(NUM_FU);

  logic              issue_en;
  logic [FU_W-1:0]   issue_fu;
  logic [OP_W-1:0]   issue_op;
  logic [REG_W-1:0]  issue_rd;
  logic [REG_W-1:0]  issue_rs1;
  logic [REG_W-1:0]  issue_rs2;
  logic [FU_W-1:0]   issue_t1;
  logic [FU_W-1:0]   issue_t2;
  logic              issue_t1_pend;
  logic              issue_t2_pend;
  logic              issue_ack;
  logic              disp_en;
  logic [FU_W-1:0]   disp_fu;
  logic              wb_en;
  logic [FU_W-1:0]   wb_fu;
  logic [NUM_FU-1:0] fu_busy;
  logic [NUM_FU-1:0] fu_ready;
  logic [NUM_FU*OP_W-1:0]  fu_op;
  logic [NUM_FU*REG_W-1:0] fu_rd;

  modport master (
    output issue_en, issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2,
    output issue_t1, issue_t2, issue_t1_pend, issue_t2_pend,
    output disp_en, disp_fu, wb_en, wb_fu,
    input  issue_ack, fu_busy, fu_ready, fu_op, fu_rd
  );

  modport slave (
    input  issue_en, issue_fu, issue_op, issue_rd, issue_rs1, issue_rs2,
    input  issue_t1, issue_t2, issue_t1_pend, issue_t2_pend,
    input  disp_en, disp_fu, wb_en, wb_fu,
    output issue_ack, fu_busy, fu_ready, fu_op, fu_rd
  );
endinterface

// File: rtl/fust_row.sv
// One FU status row: issue load, dispatch mark, writeback free and operand wake-up.
module fust_row
  import datapath_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int FU_W  = 2,
  parameter int REG_W = 5,
  parameter int OP_W  = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             issue_ack,
  input  logic [FU_W-1:0]  issue_fu,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [REG_W-1:0] issue_rd,
  input  logic [REG_W-1:0] issue_rs1,
  input  logic [REG_W-1:0] issue_rs2,
  input  logic [FU_W-1:0]  issue_t1,
  input  logic [FU_W-1:0]  issue_t2,
  input  logic             issue_t1_pend,
  input  logic             issue_t2_pend,
  input  logic             disp_en,
  input  logic [FU_W-1:0]  disp_fu,
  input  logic             wb_en,
  input  logic [FU_W-1:0]  wb_fu,
  output fust_row_t        row_q,
  output logic             ready
);

  fust_row_t row_d;
  logic      issue_sel, disp_sel, wb_sel;

  assign issue_sel = issue_ack & (issue_fu == FU_W'(IDX));
  assign disp_sel  = disp_en   & (disp_fu  == FU_W'(IDX));
  assign wb_sel    = wb_en     & (wb_fu    == FU_W'(IDX));
  assign ready     = row_ready(row_q);

  always_comb begin
    row_d = row_q;
    // Wake-up: a completing producer releases operands waiting on its tag.
    if (wb_en && !wb_sel && row_q.busy) begin
      if (!row_q.r1 && row_q.t1 == DP_TAG_W'(wb_fu)) row_d.r1 = 1'b1;
      if (!row_q.r2 && row_q.t2 == DP_TAG_W'(wb_fu)) row_d.r2 = 1'b1;
    end
    if (disp_sel && ready) row_d.disp = 1'b1;
    if (issue_sel) begin
      row_d.busy = 1'b1;
      row_d.disp = 1'b0;
      row_d.op   = DP_OP_W'(issue_op);
      row_d.rd   = DP_REG_W'(issue_rd);
      row_d.rs1  = DP_REG_W'(issue_rs1);
      row_d.rs2  = DP_REG_W'(issue_rs2);
      row_d.t1   = DP_TAG_W'(issue_t1);
      row_d.t2   = DP_TAG_W'(issue_t2);
      // Bypass a producer completing in the same cycle as the issue.
      row_d.r1   = ~issue_t1_pend | (wb_en & (issue_t1 == wb_fu));
      row_d.r2   = ~issue_t2_pend | (wb_en & (issue_t2 == wb_fu));
    end
    // Writeback wins over a same-cycle dispatch.
    if (wb_sel) begin
      row_d.busy = 1'b0;
      row_d.disp = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) row_q <= '0;
    else       row_q <= row_d;
  end

endmodule

// File: rtl/fust_table.sv
// Functional-unit status table: NUM_FU rows tracking issued ops and operand readiness.
module fust_table
  import datapath_pkg::*;
#(
  parameter int NUM_FU = 4,
  parameter int REG_W  = 5,
  parameter int OP_W   = 4
) (
  input  logic         CLK,
  input  logic         nRST,
  fust_table_if.slave  bus
);

  localparam int FU_W = $clog2(NUM_FU);

  fust_row_t         rows [NUM_FU];
  logic [NUM_FU-1:0] busy_vec;
  logic [NUM_FU-1:0] ready_vec;

  // Busy is the start-of-cycle value, so a same-cycle writeback never frees the row for issue.
  assign bus.issue_ack = bus.issue_en & ~busy_vec[bus.issue_fu];
  assign bus.fu_busy   = busy_vec;
  assign bus.fu_ready  = ready_vec;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_row
    fust_row #(
      .IDX  (i),
      .FU_W (FU_W),
      .REG_W(REG_W),
      .OP_W (OP_W)
    ) u_row (
      .CLK          (CLK),
      .nRST         (nRST),
      .issue_ack    (bus.issue_ack),
      .issue_fu     (bus.issue_fu),
      .issue_op     (bus.issue_op),
      .issue_rd     (bus.issue_rd),
      .issue_rs1    (bus.issue_rs1),
      .issue_rs2    (bus.issue_rs2),
      .issue_t1     (bus.issue_t1),
      .issue_t2     (bus.issue_t2),
      .issue_t1_pend(bus.issue_t1_pend),
      .issue_t2_pend(bus.issue_t2_pend),
      .disp_en      (bus.disp_en),
      .disp_fu      (bus.disp_fu),
      .wb_en        (bus.wb_en),
      .wb_fu        (bus.wb_fu),
      .row_q        (rows[i]),
      .ready        (ready_vec[i])
    );

    assign busy_vec[i]                  = rows[i].busy;
    assign bus.fu_op[i*OP_W +: OP_W]    = rows[i].op[OP_W-1:0];
    assign bus.fu_rd[i*REG_W +: REG_W]  = rows[i].rd[REG_W-1:0];
  end

endmodule

// File: doc/fust_table.md
FUST_TABLE -- requirements
Module: fust_table

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional-unit status rows (power of two, 2..16).
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have parameter OP_W, default 4, opcode width; FU_W = clog2(NUM_FU) derived locally.
REQ-004 SHALL have port CLK  in  1  clock, rising edge.
REQ-005 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port issue_en  in  1  request to allocate row issue_fu.
REQ-007 SHALL have port issue_fu  in  FU_W  target row.
REQ-008 SHALL have port issue_op / issue_rd / issue_rs1 / issue_rs2  in  OP_W/REG_W/REG_W/REG_W  instruction fields.
REQ-009 SHALL have port issue_t1 / issue_t2  in  FU_W each  producing-FU tag for rs1/rs2.
REQ-010 SHALL have port issue_t1_pend / issue_t2_pend  in  1 each  operand still pending on that tag.
REQ-011 SHALL have port issue_ack  out  1  combinational: issue_en & ~fu_busy[issue_fu].
REQ-012 SHALL have port disp_en / disp_fu  in  1/FU_W  operands of row disp_fu read by execute.
REQ-013 SHALL have port wb_en / wb_fu  in  1/FU_W  row wb_fu completed writeback.
REQ-014 SHALL have port fu_busy / fu_ready  out  NUM_FU each  per-row busy and ready-to-dispatch.
REQ-015 SHALL have port fu_op / fu_rd  out  NUM_FU*OP_W / NUM_FU*REG_W  per-row registered fields, row i at slice i.

Function
REQ-016 Each row SHALL hold busy, op, rd, rs1, rs2, t1, t2, r1, r2, disp; all registered.
REQ-017 Accepted issue (issue_ack=1) SHALL at next edge set busy=1, disp=0, load fields, r1=~issue_t1_pend, r2=~issue_t2_pend.
REQ-018 Issue to a busy row SHALL be rejected, row unchanged, issue_ack=0; busy is the start-of-cycle value, so wb to the same row that cycle does not enable issue.
REQ-019 Writeback SHALL at next edge clear busy and disp of row wb_fu; fields hold stale values.
REQ-020 Writeback SHALL broadcast: every busy row j != wb_fu with r1=0 and t1=wb_fu sets r1=1; same for r2/t2.
REQ-021 Same-cycle issue with issue_t1_pend=1 and issue_t1=wb_fu (wb_en=1) SHALL load r1=1 (bypass); same for t2.
REQ-022 fu_ready[i] SHALL equal busy & r1 & r2 & ~disp of row i, from registered state (visible one cycle after the enabling event).
REQ-023 disp_en SHALL set disp=1 of row disp_fu only if that row is ready; otherwise ignored.
REQ-024 disp_en and wb_en to the same row in one cycle: writeback SHALL win (row freed, disp=0).
REQ-025 Issue, dispatch and writeback to three distinct rows in one cycle SHALL all take effect.
REQ-026 Out-of-range indices (NUM_FU not power of two is disallowed) need no handling; wb_en to an idle row SHALL be a no-op except broadcast.

Reset
REQ-027 On nRST low all row state SHALL clear to 0 asynchronously; fu_busy=0, fu_ready=0, fu_op=0, fu_rd=0.
REQ-028 issue_ack SHALL be 0 while issue_en=0 and follow REQ-011 immediately after reset release.
REQ-029 Reset mid-operation SHALL discard all pending rows without broadcast.

Structure
REQ-030 Row record typedef fust_row_t (fields of REQ-016, sized by package constants) SHALL live in datapath_pkg.
REQ-031 One sub-module fust_row SHALL implement a single row (update and wake-up logic), instantiated NUM_FU times by generate.
REQ-032 Per-row next state SHALL be computed in one always_comb and registered in one always_ff per row.

Verification
REQ-033 Reset: drive nRST=0 mid-traffic -> fu_busy=0, fu_ready=0, fu_op=0 within same cycle.
REQ-034 Issue row 2 op=3 rd=7, no pending -> next cycle fu_busy=4'b0100, fu_ready=4'b0100, fu_rd[2]=7.
REQ-035 Issue row 1 with t1=0 pending, then wb_fu=0 -> fu_ready[1] 0 then 1 cycle after wb.
REQ-036 Same cycle issue row 3 t2=1 pending and wb_fu=1 -> next cycle r2 set, fu_ready[3]=1, fu_busy[1]=0.
REQ-037 Issue to busy row 0 -> issue_ack=0, row 0 fields unchanged.
REQ-038 disp_en and wb_en both row 2 same cycle -> next cycle fu_busy[2]=0, fu_ready[2]=0; reissue to row 2 accepted.
